// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared function codes, FSM state type and helpers for the
//                sequenced 64-bit ALU wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [5:0] CTL_ADD = 6'd32;
    localparam logic [5:0] CTL_SUB = 6'd34;
    localparam logic [5:0] CTL_AND = 6'd36;
    localparam logic [5:0] CTL_OR  = 6'd37;
    localparam logic [5:0] CTL_SLT = 6'd42;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic ctl_supported(input logic [5:0] ctl);
        return (ctl == CTL_ADD) || (ctl == CTL_SUB) ||
               (ctl == CTL_AND) || (ctl == CTL_OR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_wide_seq_if.sv
// ============================================================================
//  Module      : alu_wide_seq_if
//  Description : Request/response bus of the sequenced 64-bit ALU.
//                out_ovf exists only when ALU_WIDE_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_wide_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_ctl;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_carry;
    logic        out_err;
`ifdef ALU_WIDE_OVF_EN
    logic        out_ovf;
`endif

    modport master (
        output in_valid, in_ctl, in_a, in_b, out_ready,
`ifdef ALU_WIDE_OVF_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_result, out_carry, out_err
    );

    modport slave (
        input  in_valid, in_ctl, in_a, in_b, out_ready,
`ifdef ALU_WIDE_OVF_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_result, out_carry, out_err
    );

endinterface

`default_nettype wire

// File: rtl/alu_wide_seq.sv
// ============================================================================
//  Module      : alu_wide_seq
//  Description : Runs 64-bit add/sub/and/or as two passes (low then high half)
//                through an external 32-bit ALU. Optional signed-overflow
//                output enabled by macro ALU_WIDE_OVF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_wide_seq
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    alu_wide_seq_if.slave        bus,
    output logic [5:0]           alu_ctl,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic                 alu_cin,
    input  logic [31:0]          alu_result,
    input  logic                 alu_carry
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_ctl;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_res;
    logic        r_c_lo;
    logic        r_carry;
    logic        r_err;
    logic        w_accept;
    logic        w_arith;

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
    assign w_arith  = (r_ctl == CTL_ADD) || (r_ctl == CTL_SUB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) begin
                w_state_nxt = ctl_supported(bus.in_ctl) ? ST_LO : ST_DONE;
            end
            ST_LO:   w_state_nxt = ST_HI;
            ST_HI:   w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The ALU sees zeros outside LO/HI so idle cycles never toggle it.
    always_comb begin
        alu_ctl = '0;
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        case (r_state)
            ST_LO: begin
                alu_ctl = r_ctl;
                alu_a   = r_a[31:0];
                alu_b   = r_b[31:0];
                alu_cin = (r_ctl == CTL_SUB);
            end
            ST_HI: begin
                alu_ctl = r_ctl;
                alu_a   = r_a[63:32];
                alu_b   = r_b[63:32];
                alu_cin = w_arith ? r_c_lo : 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctl   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_c_lo  <= 1'b0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_ctl   <= bus.in_ctl;
                    r_a     <= bus.in_a;
                    r_b     <= bus.in_b;
                    r_res   <= '0;
                    r_c_lo  <= 1'b0;
                    r_carry <= 1'b0;
                    r_err   <= ~ctl_supported(bus.in_ctl);
                end
                ST_LO: begin
                    r_res[31:0] <= alu_result;
                    r_c_lo      <= alu_carry;
                end
                ST_HI: begin
                    r_res[63:32] <= alu_result;
                    r_carry      <= alu_carry;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_WIDE_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // Sign of the result is the MSB of the high-half ALU pass.
    always_comb begin
        w_ovf = 1'b0;
        if (r_ctl == CTL_ADD) begin
            w_ovf = (r_a[63] == r_b[63]) && (alu_result[31] != r_a[63]);
        end else if (r_ctl == CTL_SUB) begin
            w_ovf = (r_a[63] != r_b[63]) && (alu_result[31] != r_a[63]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_HI) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.out_ovf = r_ovf;
`endif

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.out_valid  = (r_state == ST_DONE);
    assign bus.out_result = r_res;
    assign bus.out_carry  = r_carry;
    assign bus.out_err    = r_err;

endmodule

`default_nettype wire
